fc_train_sequencer: RTL

- Control FSM that runs one pass over a dataset through the fully-connected forward engine, the backward engine and a weight-update engine.
- Drives each engine's start pulse and waits on its done signal.
- Presents the current sample index so upstream buffers can load input data.
- Triggers a weight update after each batch, guards every wait with a watchdog, and reports completion or error to the top-level trainer.

---
 rtl/fc_train_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/fc_train_sequencer.sv
// fc_train_sequencer: control FSM that walks one dataset through the FC
// forward, backward and weight-update engines, one sample at a time.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, abort                run request (IDLE only) / level abort to IDLE
//   train_en, num_samples,      run configuration, captured on an accepted start
//   batch_size
//   fwd/bwd/upd_start           one-cycle engine start pulses
//   fwd/bwd/upd_done            engine done levels; completion = rising edge
//   sample_idx                  sample currently being processed
//   busy, done                  not-IDLE flag / normal completion pulse
//   error, err_code             sticky error, 1 fwd / 2 bwd / 3 upd timeout
module fc_train_sequencer #(
  parameter int unsigned IDX_W   = 16,
  parameter int unsigned BATCH_W = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               train_en,
  input  logic [IDX_W-1:0]   num_samples,
  input  logic [BATCH_W-1:0] batch_size,
  output logic               fwd_start,
  input  logic               fwd_done,
  output logic               bwd_start,
  input  logic               bwd_done,
  output logic               upd_start,
  input  logic               upd_done,
  output logic [IDX_W-1:0]   sample_idx,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W:0] WD_LAST = (WD_W+1)'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FWD_GO, S_FWD_WAIT, S_BWD_GO, S_BWD_WAIT,
    S_UPD_GO, S_UPD_WAIT, S_NEXT, S_ERR
  } state_t;

  state_t             state, state_nx;
  logic               train_q, train_nx;
  logic [IDX_W-1:0]   num_q, num_nx;
  logic [BATCH_W-1:0] bsz_q, bsz_nx;
  logic [IDX_W-1:0]   idx_nx;
  logic [BATCH_W-1:0] bcnt, bcnt_nx, bcnt_inc;
  logic [WD_W-1:0]    wd, wd_nx;
  logic [WD_W:0]      wd_inc;
  logic               fwd_q, bwd_q, upd_q;
  logic               fwd_edge, bwd_edge, upd_edge;
  logic               wd_hit, last;
  logic               done_nx, error_nx;
  logic [1:0]         code_nx;

  // Completions are rising edges only, so a level left high by an earlier
  // operation cannot satisfy a fresh wait.
  assign fwd_edge = fwd_done & ~fwd_q;
  assign bwd_edge = bwd_done & ~bwd_q;
  assign upd_edge = upd_done & ~upd_q;

  // Timeout fires in the cycle the watchdog count would reach TIMEOUT-1.
  assign wd_inc   = {1'b0, wd} + (WD_W+1)'(1);
  assign wd_hit   = (wd_inc == WD_LAST);
  assign last     = (sample_idx == num_q - IDX_W'(1));
  assign bcnt_inc = bcnt + BATCH_W'(1);

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      train_q    <= 1'b0;
      num_q      <= '0;
      bsz_q      <= '0;
      sample_idx <= '0;
      bcnt       <= '0;
      wd         <= '0;
      fwd_q      <= 1'b0;
      bwd_q      <= 1'b0;
      upd_q      <= 1'b0;
      fwd_start  <= 1'b0;
      bwd_start  <= 1'b0;
      upd_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state      <= state_nx;
      train_q    <= train_nx;
      num_q      <= num_nx;
      bsz_q      <= bsz_nx;
      sample_idx <= idx_nx;
      bcnt       <= bcnt_nx;
      wd         <= wd_nx;
      fwd_q      <= fwd_done;
      bwd_q      <= bwd_done;
      upd_q      <= upd_done;
      fwd_start  <= (state_nx == S_FWD_GO);
      bwd_start  <= (state_nx == S_BWD_GO);
      upd_start  <= (state_nx == S_UPD_GO);
      busy       <= (state_nx != S_IDLE);
      done       <= done_nx;
      error      <= error_nx;
      err_code   <= code_nx;
    end
  end

  // Next-state and next-output logic; abort overrides every transition.
  always_comb begin
    state_nx = state;
    train_nx = train_q;
    num_nx   = num_q;
    bsz_nx   = bsz_q;
    idx_nx   = sample_idx;
    bcnt_nx  = bcnt;
    wd_nx    = wd;
    done_nx  = 1'b0;
    error_nx = error;
    code_nx  = err_code;

    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            train_nx = train_en;
            num_nx   = num_samples;
            bsz_nx   = batch_size;
            idx_nx   = '0;
            bcnt_nx  = '0;
            error_nx = 1'b0;
            code_nx  = 2'd0;
            if ((num_samples == '0) || (batch_size == '0)) begin
              done_nx = 1'b1;
            end else begin
              state_nx = S_FWD_GO;
            end
          end
        end
        S_FWD_GO: begin
          wd_nx    = '0;
          state_nx = S_FWD_WAIT;
        end
        S_FWD_WAIT: begin
          if (fwd_edge) begin
            state_nx = train_q ? S_BWD_GO : S_NEXT;
          end else if (wd_hit) begin
            state_nx = S_ERR;
            error_nx = 1'b1;
            code_nx  = 2'd1;
          end else begin
            wd_nx = wd_inc[WD_W-1:0];
          end
        end
        S_BWD_GO: begin
          wd_nx    = '0;
          state_nx = S_BWD_WAIT;
        end
        S_BWD_WAIT: begin
          if (bwd_edge) begin
            // A short final batch still gets its weight update.
            if ((bcnt_inc == bsz_q) || last) begin
              state_nx = S_UPD_GO;
              bcnt_nx  = '0;
            end else begin
              state_nx = S_NEXT;
              bcnt_nx  = bcnt_inc;
            end
          end else if (wd_hit) begin
            state_nx = S_ERR;
            error_nx = 1'b1;
            code_nx  = 2'd2;
          end else begin
            wd_nx = wd_inc[WD_W-1:0];
          end
        end
        S_UPD_GO: begin
          wd_nx    = '0;
          state_nx = S_UPD_WAIT;
        end
        S_UPD_WAIT: begin
          if (upd_edge) begin
            state_nx = S_NEXT;
          end else if (wd_hit) begin
            state_nx = S_ERR;
            error_nx = 1'b1;
            code_nx  = 2'd3;
          end else begin
            wd_nx = wd_inc[WD_W-1:0];
          end
        end
        S_NEXT: begin
          if (last) begin
            done_nx  = 1'b1;
            state_nx = S_IDLE;
          end else begin
            idx_nx   = sample_idx + IDX_W'(1);
            state_nx = S_FWD_GO;
          end
        end
        S_ERR: begin
          state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

endmodule
